// File: rtl/tx_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_frame_pkg
// Brief    : Shared constants, frame entry type and byte selector for the
//            SAR-to-UART frame scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package tx_frame_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [1:0] BYTE_HDR = 2'd0;
    localparam logic [1:0] BYTE_SEQ = 2'd1;
    localparam logic [1:0] BYTE_MSB = 2'd2;
    localparam logic [1:0] BYTE_LSB = 2'd3;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
    localparam int         ENTRY_W        = 24;

    typedef struct packed {
        logic [7:0]  seq;
        logic [15:0] sample;
    } frame_entry_t;

    function automatic logic [7:0] frame_byte(input frame_entry_t e,
                                              input logic [1:0]   idx,
                                              input logic [7:0]   hdr);
        logic [7:0] b;
        case (idx)
            BYTE_HDR: b = hdr;
            BYTE_SEQ: b = e.seq;
            BYTE_MSB: b = e.sample[15:8];
            default:  b = e.sample[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_frame_scheduler_if
// Brief    : Sample input, frame-start and UART handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface tx_frame_scheduler_if #(
    parameter int DATA_WIDTH = 10
);
    logic [DATA_WIDTH-1:0] sample_i;
    logic                  sample_valid_i;
    logic                  frame_start_i;
    logic                  eot_i;
    logic [7:0]            tx_data_o;
    logic                  start_tx_o;
    logic                  busy_o;
    logic                  overflow_o;

    modport master (
        output sample_i, sample_valid_i, frame_start_i, eot_i,
        input  tx_data_o, start_tx_o, busy_o, overflow_o
    );

    modport slave (
        input  sample_i, sample_valid_i, frame_start_i, eot_i,
        output tx_data_o, start_tx_o, busy_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/tx_frame_scheduler_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with registered occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign w_push_ok = i_push && (r_count < CNT_W'(DEPTH));
    assign w_pop_ok  = i_pop && (r_count != '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/tx_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_frame_scheduler
// Brief    : Queues tagged SAR samples and sends them to the UART as
//            4-byte frames {header, seq, sample[15:8], sample[7:0]}.
// Revision : 1.0 - initial release
// ============================================================================
module tx_frame_scheduler
    import tx_frame_pkg::*;
#(
    parameter int         DATA_WIDTH = 10,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] HEADER     = DEFAULT_HEADER
) (
    input  wire logic      clk_i,
    input  wire logic      rst_i,
    tx_frame_scheduler_if.slave bus
);
    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [1:0]            r_index;
    logic [1:0]            w_next_index;
    frame_entry_t          r_hold;
    frame_entry_t          w_entry;
    frame_entry_t          w_fifo_rdata;
    frame_entry_t          w_frame_src;
    logic [DATA_WIDTH-1:0] w_sample;
    logic [7:0]            r_seq;
    logic                  r_overflow;
    logic [7:0]            r_tx_data;
    logic [7:0]            w_tx_data_d;
    logic                  r_start_tx;
    logic                  w_start_tx_d;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_drop;

    assign w_sample = bus.sample_i;
    assign w_accept = bus.sample_valid_i && !w_full;
    assign w_drop   = bus.sample_valid_i && w_full;

    // A sample arriving with the ramp-start pulse is the first of the new ramp.
    assign w_entry.seq    = bus.frame_start_i ? 8'd0 : r_seq;
    assign w_entry.sample = 16'(w_sample);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (bus.sample_valid_i),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_index    <= BYTE_HDR;
            r_hold     <= '0;
            r_tx_data  <= '0;
            r_start_tx <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_index    <= w_next_index;
            r_tx_data  <= w_tx_data_d;
            r_start_tx <= w_start_tx_d;
            if (w_pop) r_hold <= w_fifo_rdata;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_index = r_index;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_index = BYTE_HDR;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (bus.eot_i) begin
                    if (r_index != BYTE_LSB) begin
                        w_next_index = r_index + 2'd1;
                        w_next_state = ST_SEND;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so they register into the SEND cycle.
    always_comb begin
        w_frame_src  = w_pop ? w_fifo_rdata : r_hold;
        w_start_tx_d = (w_next_state == ST_SEND);
        w_tx_data_d  = r_tx_data;
        if (w_next_state == ST_SEND) begin
            w_tx_data_d = frame_byte(w_frame_src, w_next_index, HEADER);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_seq      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.frame_start_i) begin
                r_seq <= w_accept ? 8'd1 : 8'd0;
            end else if (w_accept) begin
                r_seq <= r_seq + 8'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.frame_start_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.tx_data_o  = r_tx_data;
    assign bus.start_tx_o = r_start_tx;
    assign bus.overflow_o = r_overflow;
    assign bus.busy_o     = (r_state != ST_IDLE) || !w_empty;
endmodule
`default_nettype wire

// File: tb/tb_tx_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_frame_scheduler
// Brief    : Directed self-checking bench for tx_frame_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_frame_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    tx_frame_scheduler_if #(.DATA_WIDTH(10)) bus ();

    tx_frame_scheduler #(
        .DATA_WIDTH (10),
        .FIFO_DEPTH (4),
        .HEADER     (8'hA5)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_sample(input logic [9:0] v);
        bus.sample_i       = v;
        bus.sample_valid_i = 1'b1;
        tick();
        bus.sample_valid_i = 1'b0;
    endtask

    // Receives bytes 0..last of a frame; eot arrives gap+2 cycles after each start.
    task automatic recv_frame(input logic [7:0] seq, input logic [15:0] smp,
                              input bit already, input int gap,
                              input int fs_byte, input int last);
        logic [7:0] exp;
        int         t;
        for (int b = 0; b <= last; b++) begin
            case (b)
                0:       exp = 8'hA5;
                1:       exp = seq;
                2:       exp = smp[15:8];
                default: exp = smp[7:0];
            endcase
            if (!(already && b == 0)) begin
                t = 0;
                while (!bus.start_tx_o && t < 64) begin
                    tick();
                    t++;
                end
                chk($sformatf("start_seen_b%0d", b), 16'(bus.start_tx_o), 16'd1);
                if (b > 0) chk($sformatf("eot_latency_b%0d", b), 16'(t), 16'd0);
            end
            chk($sformatf("tx_data_seq%0h_b%0d", seq, b), 16'(bus.tx_data_o), 16'(exp));
            if (!(b == last && last < 3)) begin
                tick();
                chk("start_single", 16'(bus.start_tx_o), 16'd0);
                if (b == fs_byte) bus.frame_start_i = 1'b1;
                tick();
                bus.frame_start_i = 1'b0;
                for (int k = 0; k < gap; k++) tick();
                bus.eot_i = 1'b1;
                tick();
                bus.eot_i = 1'b0;
            end
        end
    endtask

    initial begin
        int starts;
        bus.sample_i       = '0;
        bus.sample_valid_i = 1'b0;
        bus.frame_start_i  = 1'b0;
        bus.eot_i          = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_tx_data", 16'(bus.tx_data_o), 16'h00);
        chk("rst_start", 16'(bus.start_tx_o), 16'd0);
        chk("rst_busy", 16'(bus.busy_o), 16'd0);
        chk("rst_overflow", 16'(bus.overflow_o), 16'd0);
        rst = 1'b0;
        tick();

        // Single sample: header start two cycles after valid, then A5,00,02,C7
        send_sample(10'h2C7);
        chk("lat_n1_start", 16'(bus.start_tx_o), 16'd0);
        tick();
        chk("lat_n2_start", 16'(bus.start_tx_o), 16'd1);
        recv_frame(8'h00, 16'h02C7, 1'b0, 1, -1, 3);
        chk("busy_after_frame", 16'(bus.busy_o), 16'd0);

        // Burst of 6 with stalled UART: holding reg + 4 FIFO slots accept 5, 6th drops
        for (int i = 0; i < 6; i++) begin
            bus.frame_start_i = (i == 0);
            send_sample(10'(i + 1));
            bus.frame_start_i = 1'b0;
        end
        chk("burst_overflow", 16'(bus.overflow_o), 16'd1);
        chk("burst_busy", 16'(bus.busy_o), 16'd1);
        recv_frame(8'd0, 16'd1, 1'b1, 1, -1, 3);
        chk("hdr_gap_m1", 16'(bus.start_tx_o), 16'd0);
        tick();
        chk("hdr_gap_m2", 16'(bus.start_tx_o), 16'd1);
        for (int i = 1; i < 5; i++) recv_frame(8'(i), 16'(i + 1), 1'b0, 1, -1, 3);
        chk("burst_drained_busy", 16'(bus.busy_o), 16'd0);
        send_sample(10'h3FF);
        recv_frame(8'd5, 16'h03FF, 1'b0, 1, -1, 3);
        chk("overflow_sticky", 16'(bus.overflow_o), 16'd1);

        // frame_start mid-frame: frame unchanged, overflow cleared, seq restarts
        send_sample(10'h111);
        recv_frame(8'd6, 16'h0111, 1'b0, 1, 1, 3);
        chk("fs_clears_overflow", 16'(bus.overflow_o), 16'd0);
        send_sample(10'h222);
        recv_frame(8'd0, 16'h0222, 1'b0, 1, -1, 3);
        bus.frame_start_i = 1'b1;
        send_sample(10'h333);
        bus.frame_start_i = 1'b0;
        send_sample(10'h044);
        recv_frame(8'd0, 16'h0333, 1'b0, 1, -1, 3);
        recv_frame(8'd1, 16'h0044, 1'b0, 1, -1, 3);

        // 257 samples with prompt eot: seq wraps FF -> 00 without overflow
        for (int i = 0; i < 257; i++) begin
            bus.frame_start_i = (i == 0);
            send_sample(10'(i));
            bus.frame_start_i = 1'b0;
            recv_frame(8'(i), 16'(i), 1'b0, 0, -1, 3);
        end
        chk("wrap_no_overflow", 16'(bus.overflow_o), 16'd0);

        // Reset during byte2 WAIT with two samples queued
        send_sample(10'h155);
        send_sample(10'h0AA);
        send_sample(10'h2F0);
        recv_frame(8'd1, 16'h0155, 1'b1, 1, -1, 2);
        tick();
        chk("pre_rst_busy", 16'(bus.busy_o), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tx_data", 16'(bus.tx_data_o), 16'h00);
        chk("midrst_start", 16'(bus.start_tx_o), 16'd0);
        chk("midrst_busy", 16'(bus.busy_o), 16'd0);
        chk("midrst_overflow", 16'(bus.overflow_o), 16'd0);
        starts = 0;
        for (int k = 0; k < 20; k++) begin
            bus.eot_i = (k == 5);
            tick();
            if (bus.start_tx_o) starts++;
        end
        bus.eot_i = 1'b0;
        chk("post_rst_starts", 16'(starts), 16'd0);
        chk("post_rst_busy", 16'(bus.busy_o), 16'd0);
        chk("post_rst_tx_data", 16'(bus.tx_data_o), 16'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
